alkshseq: RTL and testbench
===========================

// Module: alkshseq
// PURPOSE
//  Multi-bit shift sequencer for the ALK ALU shift path. Accepts a shift
//  command (direction, count, fill mode) and performs it as N single-bit
//  ALU shift steps, one per clock. Each step drives the SHL/SHR op decode
//  and the shift-in bit into the ALU SIO routing logic, and captures the
//  bit shifted out. Sits between microcode control and the SIO routing.
// PARAMETERS
//  CNT_W   5   width of shift count; max count 2**CNT_W-1 (31)
// PORTS
//  clk_h            in   1      single clock, rising edge
//  reset_l          in   1      asynchronous, active-low reset
//  start_h          in   1      command strobe; sampled only in IDLE
//  dir_h            in   1      1 = SHR (sin->ALU[31]), 0 = SHL (sin->ALU[0])
//  mode_h           in   2      fill: 00 zero, 01 one, 10 rotate, 11 arith
//  count_h          in   CNT_W  number of single-bit steps
//  abort_h          in   1      cancel current command
//  alu_msb_h        in   1      current ALU[31], used for arith SHR fill
//  alu_sout_shl_h   in   1      bit shifted out on SHL step
//  alu_sout_shr_h   in   1      bit shifted out on SHR step
//  alpctl_shl_op_h  out  1      SHL step enable to SIO routing
//  alpctl_shr_op_h  out  1      SHR step enable to SIO routing
//  alu_sin_h        out  1      bit shifted into ALU this step
//  busy_h           out  1      command in progress (SHIFT or DONE)
//  done_h           out  1      one-cycle completion pulse
//  last_bit_h       out  1      last bit shifted out (shift carry)
// BEHAVIOUR
//  Reset (reset_l=0, any time, incl. mid-command): state IDLE, all
//   outputs 0, remaining count 0, latched dir/mode 0. Release is
//   synchronous to the next clk_h edge.
//  States: IDLE, SHIFT, DONE.
//  IDLE: start_h=1 at edge -> latch dir/mode/count; count!=0 -> SHIFT
//   with rem=count; count==0 -> DONE (no step, last_bit_h unchanged).
//  SHIFT: exactly one of shl/shr_op_h = 1 per latched dir; other 0.
//   At each edge: rem decrements; last_bit_h <= selected sout
//   (shr: alu_sout_shr_h, shl: alu_sout_shl_h). rem reaches 0 -> DONE.
//   Exactly N cycles with op asserted for count N.
//  DONE: ops 0, done_h=1 for this single cycle -> IDLE next edge.
//  busy_h = 1 in SHIFT and DONE; 0 in IDLE.
//  alu_sin_h (combinational, 0 when no op asserted):
//   00 -> 0; 01 -> 1; 10 -> selected sout of the same cycle (rotate);
//   11 -> SHR: alu_msb_h (sign fill); SHL: 0.
//  start_h while busy_h=1 is ignored (not queued).
//  abort_h in SHIFT: ops drop next cycle, -> IDLE, no done_h pulse;
//   last_bit_h keeps value from last completed step. abort_h in IDLE or
//   DONE has no effect. abort_h with start_h in IDLE: start wins.
//  Command latency: start edge -> first step cycle = 1 clock; done_h
//   appears count+1 cycles after start edge (1 cycle for count 0).
//  Back-to-back: start_h may be asserted in the cycle after DONE.
// TESTING
//  reset_l low mid-SHIFT (count 20, step 7) -> all outputs 0 at once,
//   IDLE after release, no done_h.
//  SHL, mode 00, count 3 -> shl_op_h high 3 cycles, sin 0, done_h
//   on 4th cycle after start; last_bit_h = 3rd alu_sout_shl_h sample.
//  SHR, mode 11, alu_msb_h=1, count 31 -> shr_op_h high 31 cycles,
//   sin 1 each step; busy_h high 32 cycles.
//  Rotate SHR, sout pattern 1,0,1 over count 3 -> alu_sin_h follows
//   1,0,1 in same cycles.
//  count 0 -> no op asserted, done_h on cycle after start, busy 1 cycle.
//  start during SHIFT ignored; abort at step 2 of 5 -> IDLE, no done_h.

Source files
------------

// File: rtl/alkshseq.sv
// Multi-bit ALU shift sequencer: runs a latched command as one single-bit shift step per clock.
// Latency: first step 1 clock after start, done_h count+1 clocks after start. No backpressure: start_h is ignored while busy_h.
module alkshseq #(
  parameter int CNT_W = 5
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             start_h,
  input  logic             dir_h,
  input  logic [1:0]       mode_h,
  input  logic [CNT_W-1:0] count_h,
  input  logic             abort_h,
  input  logic             alu_msb_h,
  input  logic             alu_sout_shl_h,
  input  logic             alu_sout_shr_h,
  output logic             alpctl_shl_op_h,
  output logic             alpctl_shr_op_h,
  output logic             alu_sin_h,
  output logic             busy_h,
  output logic             done_h,
  output logic             last_bit_h
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_dir;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_rem;
  logic             r_last_bit;
  logic             w_op;
  logic             w_sout;
  logic             w_sin;

  assign w_op   = (r_state == S_SHIFT);
  assign w_sout = r_dir ? alu_sout_shr_h : alu_sout_shl_h;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_h) begin
          w_next = (count_h != '0) ? S_SHIFT : S_DONE;
        end
      end
      // Abort takes priority over the final step's transition to DONE.
      S_SHIFT: begin
        if (abort_h) begin
          w_next = S_IDLE;
        end else if (r_rem == CNT_W'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sin = 1'b0;
    if (w_op) begin
      case (r_mode)
        2'b00:   w_sin = 1'b0;
        2'b01:   w_sin = 1'b1;
        2'b10:   w_sin = w_sout;
        2'b11:   w_sin = r_dir & alu_msb_h;
        default: w_sin = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An aborted step is not counted: neither rem nor the carry bit moves on that edge.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      r_dir      <= 1'b0;
      r_mode     <= 2'b00;
      r_rem      <= '0;
      r_last_bit <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start_h) begin
        r_dir  <= dir_h;
        r_mode <= mode_h;
        r_rem  <= count_h;
      end else if (w_op && !abort_h) begin
        r_rem      <= r_rem - CNT_W'(1);
        r_last_bit <= w_sout;
      end
    end
  end

  assign alpctl_shl_op_h = w_op & ~r_dir;
  assign alpctl_shr_op_h = w_op & r_dir;
  assign alu_sin_h       = w_sin;
  assign busy_h          = (r_state != S_IDLE);
  assign done_h          = (r_state == S_DONE);
  assign last_bit_h      = r_last_bit;

endmodule

// File: tb/tb_alkshseq.sv
// Directed bench for alkshseq: hand-computed expectations checked with immediate assertions.
module tb_alkshseq;

  logic       clk_h;
  logic       reset_l;
  logic       start_h;
  logic       dir_h;
  logic [1:0] mode_h;
  logic [4:0] count_h;
  logic       abort_h;
  logic       alu_msb_h;
  logic       alu_sout_shl_h;
  logic       alu_sout_shr_h;
  logic       shl_op;
  logic       shr_op;
  logic       sin;
  logic       busy;
  logic       done;
  logic       last_bit;

  int total = 0;
  int bad   = 0;
  int nb;
  int nbad;
  logic [2:0] pat;

  alkshseq #(.CNT_W(5)) dut (
    .clk_h           (clk_h),
    .reset_l         (reset_l),
    .start_h         (start_h),
    .dir_h           (dir_h),
    .mode_h          (mode_h),
    .count_h         (count_h),
    .abort_h         (abort_h),
    .alu_msb_h       (alu_msb_h),
    .alu_sout_shl_h  (alu_sout_shl_h),
    .alu_sout_shr_h  (alu_sout_shr_h),
    .alpctl_shl_op_h (shl_op),
    .alpctl_shr_op_h (shr_op),
    .alu_sin_h       (sin),
    .busy_h          (busy),
    .done_h          (done),
    .last_bit_h      (last_bit)
  );

  initial clk_h = 1'b0;
  always #5 clk_h = ~clk_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_shl"},  32'(shl_op),   32'd0);
    chk({tag, "_shr"},  32'(shr_op),   32'd0);
    chk({tag, "_sin"},  32'(sin),      32'd0);
    chk({tag, "_busy"}, 32'(busy),     32'd0);
    chk({tag, "_done"}, 32'(done),     32'd0);
    chk({tag, "_last"}, 32'(last_bit), 32'd0);
  endtask

  initial begin
    reset_l = 1'b0; start_h = 1'b0; dir_h = 1'b0; mode_h = 2'b00; count_h = '0;
    abort_h = 1'b0; alu_msb_h = 1'b0; alu_sout_shl_h = 1'b0; alu_sout_shr_h = 1'b0;
    #3;
    chk_all_zero("reset");
    tick(); tick();
    reset_l = 1'b1;
    tick();
    #1 chk("idle_busy", 32'(busy), 32'd0);

    // SHL, zero fill, count 3, shifted-out bits 1,0,1
    start_h = 1'b1; dir_h = 1'b0; mode_h = 2'b00; count_h = 5'd3;
    #1 chk("shl3_pre_busy", 32'(busy), 32'd0);
    tick(); start_h = 1'b0; alu_sout_shl_h = 1'b1;
    #1 chk("shl3_s1_shl", 32'(shl_op), 32'd1);
    chk("shl3_s1_shr", 32'(shr_op), 32'd0);
    chk("shl3_s1_sin", 32'(sin), 32'd0);
    chk("shl3_s1_busy", 32'(busy), 32'd1);
    tick(); alu_sout_shl_h = 1'b0;
    #1 chk("shl3_s2_shl", 32'(shl_op), 32'd1);
    chk("shl3_s2_last", 32'(last_bit), 32'd1);
    tick(); alu_sout_shl_h = 1'b1;
    #1 chk("shl3_s3_shl", 32'(shl_op), 32'd1);
    chk("shl3_s3_last", 32'(last_bit), 32'd0);
    chk("shl3_s3_sin", 32'(sin), 32'd0);
    tick();
    #1 chk("shl3_done", 32'(done), 32'd1);
    chk("shl3_done_shl", 32'(shl_op), 32'd0);
    chk("shl3_done_busy", 32'(busy), 32'd1);
    chk("shl3_last", 32'(last_bit), 32'd1);
    tick();
    #1 chk("shl3_idle_done", 32'(done), 32'd0);
    chk("shl3_idle_busy", 32'(busy), 32'd0);

    // count 0: straight to DONE, no step, carry bit untouched
    start_h = 1'b1; dir_h = 1'b1; mode_h = 2'b01; count_h = 5'd0; alu_sout_shr_h = 1'b0;
    tick(); start_h = 1'b0;
    #1 chk("c0_done", 32'(done), 32'd1);
    chk("c0_busy", 32'(busy), 32'd1);
    chk("c0_shr", 32'(shr_op), 32'd0);
    chk("c0_shl", 32'(shl_op), 32'd0);
    chk("c0_sin", 32'(sin), 32'd0);
    chk("c0_last", 32'(last_bit), 32'd1);
    tick();
    #1 chk("c0_idle_busy", 32'(busy), 32'd0);
    chk("c0_idle_done", 32'(done), 32'd0);

    // Back-to-back rotate SHR, count 3, sout 1,0,1 (shl sout driven opposite)
    pat = 3'b101;
    start_h = 1'b1; dir_h = 1'b1; mode_h = 2'b10; count_h = 5'd3;
    tick(); start_h = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_sout_shr_h = pat[i];
      alu_sout_shl_h = ~pat[i];
      #1 chk($sformatf("rot_s%0d_sin", i + 1), 32'(sin), 32'(pat[i]));
      chk($sformatf("rot_s%0d_shr", i + 1), 32'(shr_op), 32'd1);
      tick();
    end
    #1 chk("rot_done", 32'(done), 32'd1);
    chk("rot_last", 32'(last_bit), 32'd1);
    chk("rot_done_sin", 32'(sin), 32'd0);
    tick();

    // Arithmetic SHR, sign 1, count 31
    start_h = 1'b1; dir_h = 1'b1; mode_h = 2'b11; count_h = 5'd31; alu_msb_h = 1'b1;
    tick(); start_h = 1'b0;
    nb = 0; nbad = 0;
    for (int i = 0; i < 31; i++) begin
      alu_sout_shr_h = i[0];
      #1;
      if (busy) nb++;
      if (shr_op !== 1'b1 || shl_op !== 1'b0 || sin !== 1'b1) nbad++;
      tick();
    end
    chk("ari_step_errs", 32'(nbad), 32'd0);
    #1 if (busy) nb++;
    chk("ari_done", 32'(done), 32'd1);
    chk("ari_done_sin", 32'(sin), 32'd0);
    chk("ari_last", 32'(last_bit), 32'd0);
    tick();
    #1 if (busy) nb++;
    chk("ari_busy_cycles", 32'(nb), 32'd32);
    chk("ari_idle_busy", 32'(busy), 32'd0);

    // SHL ones-fill count 5: start ignored at step 1, abort at step 2
    alu_msb_h = 1'b0; alu_sout_shl_h = 1'b1;
    start_h = 1'b1; dir_h = 1'b0; mode_h = 2'b01; count_h = 5'd5;
    tick(); dir_h = 1'b1; count_h = 5'd2;
    #1 chk("ab_s1_shl", 32'(shl_op), 32'd1);
    chk("ab_s1_sin", 32'(sin), 32'd1);
    tick(); start_h = 1'b0; abort_h = 1'b1; dir_h = 1'b0;
    #1 chk("ab_s2_shl", 32'(shl_op), 32'd1);
    chk("ab_s2_shr", 32'(shr_op), 32'd0);
    tick(); abort_h = 1'b0;
    #1 chk("ab_shl_drop", 32'(shl_op), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    nb = 0;
    repeat (6) begin
      tick();
      #1 if (done || busy) nb++;
    end
    chk("ab_quiet", 32'(nb), 32'd0);

    // start with abort in IDLE: start wins
    start_h = 1'b1; abort_h = 1'b1; dir_h = 1'b0; mode_h = 2'b00; count_h = 5'd2;
    tick(); start_h = 1'b0; abort_h = 1'b0;
    #1 chk("sa_busy", 32'(busy), 32'd1);
    chk("sa_shl", 32'(shl_op), 32'd1);
    tick(); tick();
    #1 chk("sa_done", 32'(done), 32'd1);
    tick();

    // Reset mid-SHIFT at step 7 of 20
    start_h = 1'b1; dir_h = 1'b0; mode_h = 2'b01; count_h = 5'd20; alu_sout_shl_h = 1'b1;
    tick(); start_h = 1'b0;
    repeat (6) tick();
    #1 chk("rm_s7_shl", 32'(shl_op), 32'd1);
    chk("rm_s7_last", 32'(last_bit), 32'd1);
    reset_l = 1'b0;
    #1 chk_all_zero("rm_async");
    tick(); tick();
    reset_l = 1'b1;
    nb = 0;
    repeat (25) begin
      tick();
      #1 if (done || busy || shl_op) nb++;
    end
    chk("rm_idle_after", 32'(nb), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
